// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard scoreboard for the 5-stage pipeline.
// Keeps a shift register of in-flight writer tags (EX..WB), produces a
// per-read-port forward select and a load-use stall, and honours freeze/flush.
// Optional statistics counters: define FWD_SCOREBOARD_STAT_EN.

package fwd_scoreboard_pkg;

    // One in-flight instruction tag
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       load;
        logic [4:0] rd;
    } tag_t;

endpackage

module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int unsigned NPORT    = 2,
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned LOAD_RDY = 2,
    parameter int unsigned SELW     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic                    id_reg_write,
    input  logic                    id_is_load,
    input  logic [4:0]              id_rd,
    input  logic [NPORT*5-1:0]      id_rs,
    input  logic [NPORT-1:0]        id_rs_used,
    input  logic                    mem_stall,
    input  logic                    flush,
    output logic                    stall_id,
    output logic [NPORT*SELW-1:0]   fwd_sel,
    output logic                    ex_tag_valid
`ifdef FWD_SCOREBOARD_STAT_EN
    ,
    output logic [31:0]             stat_stall_cnt,
    output logic [31:0]             stat_fwd_cnt
`endif
);

    localparam int unsigned RW = 5;

    // tag_q[j] holds the tag of pipeline stage j+1 (j=0 is EX)
    tag_t [NSTAGE-1:0]      tag_q;
    logic [NSTAGE-1:0]      writer_c;
    logic [NPORT-1:0]       hazard_c;
    logic [NPORT*SELW-1:0]  fwd_sel_c;
    logic                   stall_c;
    tag_t                   ex_entry_c;

    // Writer qualification: x0 never counts as a destination
    always_comb begin
        writer_c = '0;
        for (int unsigned j = 0; j < NSTAGE; j++) begin
            writer_c[j] = tag_q[j].valid && tag_q[j].wr && (tag_q[j].rd != '0);
        end
    end

    // Youngest-match search per port; scanning oldest to youngest lets younger hits shadow older ones
    always_comb begin
        int unsigned j;
        fwd_sel_c = '0;
        hazard_c  = '0;
        j         = 0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            for (int unsigned n = 0; n < NSTAGE; n++) begin
                j = NSTAGE - 1 - n;
                if (id_rs_used[i] && writer_c[j] && (tag_q[j].rd == id_rs[RW*i +: RW])) begin
                    fwd_sel_c[SELW*i +: SELW] = SELW'(j + 1);
                    hazard_c[i]               = tag_q[j].load && ((j + 1) < LOAD_RDY);
                end
            end
        end
    end

    // Stall only for a live, non-flushed ID instruction
    always_comb begin
        stall_c = id_valid && !flush && (|hazard_c);
    end

    // Entry presented to EX: bubble when stalled, flushed or empty
    always_comb begin
        ex_entry_c = '0;
        if (!(stall_c || flush || !id_valid)) begin
            ex_entry_c.valid = 1'b1;
            ex_entry_c.wr    = id_reg_write;
            ex_entry_c.load  = id_is_load;
            ex_entry_c.rd    = id_rd;
        end
    end

    // Tag shift register; mem_stall freezes every stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else if (!mem_stall) begin
            tag_q[0] <= ex_entry_c;
            for (int unsigned j = 1; j < NSTAGE; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    assign stall_id     = stall_c;
    assign fwd_sel      = fwd_sel_c;
    assign ex_tag_valid = tag_q[0].valid;

`ifdef FWD_SCOREBOARD_STAT_EN
    logic [31:0] stat_stall_q;
    logic [31:0] stat_fwd_q;

    // Saturating counters for stall cycles and forwarding cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q <= '0;
            stat_fwd_q   <= '0;
        end else begin
            if (stall_c && !mem_stall && (stat_stall_q != 32'hFFFF_FFFF)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
            if (!stall_c && !mem_stall && (|fwd_sel_c) && (stat_fwd_q != 32'hFFFF_FFFF)) begin
                stat_fwd_q <= stat_fwd_q + 32'd1;
            end
        end
    end

    assign stat_stall_cnt = stat_stall_q;
    assign stat_fwd_cnt   = stat_fwd_q;
`else
    // No statistics logic in this build
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed testbench for fwd_scoreboard (default parameters, statistics disabled).
module tb_fwd_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic       id_reg_write;
    logic       id_is_load;
    logic [4:0] id_rd;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       mem_stall;
    logic       flush;
    logic       stall_id;
    logic [3:0] fwd_sel;
    logic       ex_tag_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_rd        (id_rd),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .mem_stall    (mem_stall),
        .flush        (flush),
        .stall_id     (stall_id),
        .fwd_sel      (fwd_sel),
        .ex_tag_valid (ex_tag_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic ld, input logic [4:0] rd,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic ms, input logic fl);
        id_valid     = v;
        id_reg_write = wr;
        id_is_load   = ld;
        id_rd        = rd;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
        mem_stall    = ms;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0);
        #2;
        chk("reset_stall", 32'(stall_id), 32'd0);
        chk("reset_fwd", 32'(fwd_sel), 32'd0);
        chk("reset_extv", 32'(ex_tag_valid), 32'd0);
        #7 rst_n = 1'b1;

        // ALU chain: add x5 then add x6,x5
        drive(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        chk("alu_extv", 32'(ex_tag_valid), 32'd1);
        drive(1, 1, 0, 5'd6, 5'd5, 5'd5, 2'b11, 0, 0);
        chk("alu_fwd1", 32'(fwd_sel), 32'h5);
        chk("alu_stall", 32'(stall_id), 32'd0);
        tick();
        drive(0, 0, 0, 5'd0, 5'd5, 5'd6, 2'b11, 0, 0);
        chk("alu_fwd2", 32'(fwd_sel), 32'h6);
        tick();
        chk("bubble_extv", 32'(ex_tag_valid), 32'd0);
        chk("alu_fwd3", 32'(fwd_sel), 32'hB);

        // Shadowing: x5 in stages 1 and 3, x9 in stage 2
        drive(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 0, 5'd9, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(0, 0, 0, 5'd0, 5'd5, 5'd9, 2'b11, 0, 0);
        chk("shadow_fwd", 32'(fwd_sel), 32'h9);

        // Load-use: lw x7 in EX, ID reads x7
        drive(1, 1, 1, 5'd7, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 0, 5'd8, 5'd7, 5'd0, 2'b01, 0, 0);
        chk("lu_stall", 32'(stall_id), 32'd1);
        tick();
        chk("lu_clear", 32'(stall_id), 32'd0);
        chk("lu_fwd2", 32'(fwd_sel), 32'h2);
        chk("lu_bubble", 32'(ex_tag_valid), 32'd0);
        tick();
        chk("lu_issue", 32'(ex_tag_valid), 32'd1);

        // x0 and unused ports
        drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0);
        chk("x0_fwd_a", 32'(fwd_sel), 32'd0);
        tick();
        drive(0, 0, 0, 5'd0, 5'd8, 5'd8, 2'b10, 0, 0);
        chk("unused_fwd", 32'(fwd_sel), 32'h8);
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0);
        chk("x0_fwd_b", 32'(fwd_sel), 32'd0);
        drive(1, 1, 1, 5'd10, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 0, 0, 5'd0, 5'd10, 5'd0, 2'b00, 0, 0);
        chk("unused_nostall", 32'(stall_id), 32'd0);
        chk("unused_fwd0", 32'(fwd_sel), 32'd0);
        drive(1, 0, 0, 5'd0, 5'd10, 5'd0, 2'b01, 0, 0);
        chk("used_stall", 32'(stall_id), 32'd1);

        // Freeze: stage1=lw x10, stage2=x0 writer, stage3=x8
        drive(0, 0, 0, 5'd0, 5'd10, 5'd8, 2'b11, 1, 0);
        chk("frz_fwd0", 32'(fwd_sel), 32'hD);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("frz_fwd", 32'(fwd_sel), 32'hD);
            chk("frz_extv", 32'(ex_tag_valid), 32'd1);
        end
        drive(1, 0, 0, 5'd0, 5'd10, 5'd0, 2'b01, 1, 0);
        chk("frz_stall", 32'(stall_id), 32'd1);

        // Flush beats the hazard and inserts a bubble
        drive(1, 1, 0, 5'd11, 5'd10, 5'd0, 2'b01, 0, 1);
        chk("flush_stall", 32'(stall_id), 32'd0);
        tick();
        drive(0, 0, 0, 5'd0, 5'd10, 5'd0, 2'b01, 0, 0);
        chk("flush_extv", 32'(ex_tag_valid), 32'd0);
        chk("flush_fwd", 32'(fwd_sel), 32'h2);

        // Async reset with a full pipe
        drive(1, 1, 0, 5'd12, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 0, 5'd13, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(1, 1, 0, 5'd14, 5'd0, 5'd0, 2'b00, 0, 0);
        tick();
        drive(0, 0, 0, 5'd0, 5'd12, 5'd13, 2'b11, 0, 0);
        chk("full_fwd", 32'(fwd_sel), 32'hB);
        chk("full_extv", 32'(ex_tag_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_fwd", 32'(fwd_sel), 32'd0);
        chk("arst_stall", 32'(stall_id), 32'd0);
        chk("arst_extv", 32'(ex_tag_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_fwd", 32'(fwd_sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
